// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write port arbiter between pipeline writeback and MDU, with MDU starvation guard.
// Optional build macro WB_ARB_STATS_EN adds FORCE_CNT/CONFLICT_CNT statistics outputs.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        P_WE,
  input  logic [4:0]  P_A3,
  input  logic [31:0] P_WD,
  input  logic [31:0] P_PC,
  output logic        P_STALL,
  input  logic        M_VALID,
  input  logic [4:0]  M_A3,
  input  logic [31:0] M_WD,
  input  logic [31:0] M_PC,
  output logic        M_READY,
  output logic        RF_WE,
  output logic [4:0]  RF_A3,
  output logic [31:0] RF_WD,
  output logic [31:0] RF_PC
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0] FORCE_CNT,
  output logic [31:0] CONFLICT_CNT
`endif
);
  typedef enum logic {NORMAL, FORCE} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT - 1);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic p_req, m_req, grant_p, grant_m;
  always_comb begin
    p_req   = P_WE && P_A3 != 5'd0;
    m_req   = M_VALID && M_A3 != 5'd0;
    grant_m = !RESET && m_req && (state_q == FORCE || !p_req);
    grant_p = !RESET && p_req && state_q == NORMAL;
    RF_WE   = grant_p || grant_m;
    RF_A3   = grant_p ? P_A3 : (grant_m ? M_A3 : 5'd0);
    RF_WD   = grant_p ? P_WD : (grant_m ? M_WD : 32'd0);
    RF_PC   = grant_p ? P_PC : (grant_m ? M_PC : 32'd0);
    // zero-destination MDU results are retired without touching the port
    M_READY = grant_m || (!RESET && M_VALID && M_A3 == 5'd0);
    P_STALL = !RESET && state_q == FORCE && m_req && p_req;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == FORCE) begin
      state_d = NORMAL;
      cnt_d   = 4'd0;
    end else if (p_req && m_req) begin
      state_d = (cnt_q == LIM) ? FORCE : NORMAL;
      cnt_d   = (cnt_q == LIM) ? 4'd0 : cnt_q + 4'd1;
    end else if (m_req) begin
      cnt_d   = 4'd0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= NORMAL;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef WB_ARB_STATS_EN
  logic [31:0] force_cnt_q, conflict_cnt_q;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      force_cnt_q    <= 32'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      force_cnt_q    <= force_cnt_q + 32'(grant_m && state_q == FORCE);
      conflict_cnt_q <= conflict_cnt_q + 32'(p_req && m_req);
    end
  end
  assign FORCE_CNT    = force_cnt_q;
  assign CONFLICT_CNT = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: vector table, directed corner sequences and randomized run against a deny-count reference model.
module tb_wb_port_arbiter;
  localparam int LIMIT = 3;
  logic        CLK = 1'b0;
  logic        RESET, P_WE, M_VALID;
  logic [4:0]  P_A3, M_A3;
  logic [31:0] P_WD, P_PC, M_WD, M_PC;
  logic        P_STALL, M_READY, RF_WE;
  logic [4:0]  RF_A3;
  logic [31:0] RF_WD, RF_PC;
`ifdef WB_ARB_STATS_EN
  logic [31:0] FORCE_CNT, CONFLICT_CNT;
`endif
  int n_checks = 0;
  int n_fail = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .P_WE(P_WE), .P_A3(P_A3), .P_WD(P_WD), .P_PC(P_PC), .P_STALL(P_STALL),
    .M_VALID(M_VALID), .M_A3(M_A3), .M_WD(M_WD), .M_PC(M_PC), .M_READY(M_READY),
    .RF_WE(RF_WE), .RF_A3(RF_A3), .RF_WD(RF_WD), .RF_PC(RF_PC)
`ifdef WB_ARB_STATS_EN
    , .FORCE_CNT(FORCE_CNT), .CONFLICT_CNT(CONFLICT_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [31:0] pc, input logic mr, input logic ps);
    chk({tag, ".RF_WE"}, 32'(RF_WE), 32'(we));
    chk({tag, ".RF_A3"}, 32'(RF_A3), 32'(a3));
    chk({tag, ".RF_WD"}, RF_WD, wd);
    chk({tag, ".RF_PC"}, RF_PC, pc);
    chk({tag, ".M_READY"}, 32'(M_READY), 32'(mr));
    chk({tag, ".P_STALL"}, 32'(P_STALL), 32'(ps));
  endtask

  task automatic set_in(input logic pwe, input logic [4:0] pa3, input logic [31:0] pwd, input logic [31:0] ppc,
                        input logic mv, input logic [4:0] ma3, input logic [31:0] mwd, input logic [31:0] mpc);
    P_WE = pwe; P_A3 = pa3; P_WD = pwd; P_PC = ppc;
    M_VALID = mv; M_A3 = ma3; M_WD = mwd; M_PC = mpc;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    RESET = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (cycles) begin
      #1 chk_out("reset", 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
    end
    RESET = 1'b0;
  endtask

  typedef struct {
    logic pwe; logic [4:0] pa3; logic [31:0] pwd, ppc;
    logic mv;  logic [4:0] ma3; logic [31:0] mwd, mpc;
    logic we;  logic [4:0] a3;  logic [31:0] wd, pc;
    logic mrdy, pst;
  } vec_t;
  vec_t tbl[8];

  // reference model state: consecutive conflict cycles the MDU has lost
  int denies, m_forces, m_conflicts;
  logic mv;
  logic [4:0] ma3;
  logic [31:0] mwd, mpc;

  initial begin
    RESET = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = '{0, 0, 0, 0,               0, 0, 0, 0,                     0, 0, 0, 0,                     0, 0};
    tbl[1] = '{0, 0, 0, 0,               1, 5, 32'h1234, 32'h100,        1, 5, 32'h1234, 32'h100,        1, 0};
    tbl[2] = '{1, 3, 32'haaaa, 32'h200,  0, 0, 0, 0,                     1, 3, 32'haaaa, 32'h200,        0, 0};
    tbl[3] = '{1, 3, 32'haaaa, 32'h200,  1, 5, 32'h1234, 32'h100,        1, 3, 32'haaaa, 32'h200,        0, 0};
    tbl[4] = '{1, 9, 32'hbeef, 32'h300,  1, 0, 32'h5555, 32'h400,        1, 9, 32'hbeef, 32'h300,        1, 0};
    tbl[5] = '{1, 0, 32'hcafe, 32'h500,  0, 0, 0, 0,                     0, 0, 0, 0,                     0, 0};
    tbl[6] = '{1, 0, 32'hcafe, 32'h500,  1, 6, 32'h6666, 32'h600,        1, 6, 32'h6666, 32'h600,        1, 0};
    tbl[7] = '{1, 0, 32'hcafe, 32'h500,  1, 0, 32'h7777, 32'h700,        0, 0, 0, 0,                     1, 0};

    do_reset(2);
    @(negedge CLK);
    #1 chk_out("idle", 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      do_reset(1);
      set_in(tbl[i].pwe, tbl[i].pa3, tbl[i].pwd, tbl[i].ppc, tbl[i].mv, tbl[i].ma3, tbl[i].mwd, tbl[i].mpc);
      #1 chk_out($sformatf("vec%0d", i), tbl[i].we, tbl[i].a3, tbl[i].wd, tbl[i].pc, tbl[i].mrdy, tbl[i].pst);
    end

    // starvation: pipeline wins LIMIT times, then one forced MDU cycle
    do_reset(1);
    set_in(1, 9, 32'h9999, 32'h900, 1, 7, 32'h77, 32'h700);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) @(negedge CLK);
      #1;
      if (c == 4) chk_out($sformatf("starve%0d", c), 1, 7, 32'h77, 32'h700, 1, 1);
      else        chk_out($sformatf("starve%0d", c), 1, 9, 32'h9999, 32'h900, 0, 0);
`ifdef WB_ARB_STATS_EN
      if (c == 5) begin
        chk("stats.FORCE_CNT", FORCE_CNT, 32'd1);
        chk("stats.CONFLICT_CNT", CONFLICT_CNT, 32'd4);
      end
`endif
    end
    do_reset(1);
`ifdef WB_ARB_STATS_EN
    chk("stats.FORCE_CNT_rst", FORCE_CNT, 32'd0);
    chk("stats.CONFLICT_CNT_rst", CONFLICT_CNT, 32'd0);
`endif

    // reset landing on the FORCE cycle
    set_in(1, 9, 32'h9999, 32'h900, 1, 7, 32'h77, 32'h700);
    repeat (LIMIT) @(negedge CLK);
    RESET = 1'b1;
    #1 chk_out("rstforce", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 1; c <= LIMIT; c++) begin
      #1 chk_out($sformatf("postrst%0d", c), 1, 9, 32'h9999, 32'h900, 0, 0);
      @(negedge CLK);
    end
    P_WE = 1'b0;
    #1 chk_out("postrst_mdu", 1, 7, 32'h77, 32'h700, 1, 0);

    // randomized run against the deny-count model
    do_reset(1);
    denies = 0; m_forces = 0; m_conflicts = 0; mv = 1'b0; ma3 = 0; mwd = 0; mpc = 0;
    for (int i = 0; i < 400; i++) begin
      logic pr, mrq, frc, gm, gp, e_mrdy;
      @(negedge CLK);
      RESET = ($urandom_range(0, 39) == 0);
      if (!mv && $urandom_range(0, 2) == 0) begin
        mv = 1'b1; ma3 = 5'($urandom_range(0, 7)); mwd = $urandom; mpc = $urandom;
      end
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom, $urandom, mv, ma3, mwd, mpc);
      pr  = P_WE && P_A3 != 0;
      mrq = mv && ma3 != 0;
      frc = mrq && denies >= LIMIT;
      gm  = !RESET && mrq && (!pr || frc);
      gp  = !RESET && pr && !gm;
      e_mrdy = gm || (!RESET && mv && ma3 == 0);
      #1;
      chk_out($sformatf("rnd%0d", i), gp || gm,
              gp ? P_A3 : (gm ? ma3 : 5'd0),
              gp ? P_WD : (gm ? mwd : 32'd0),
              gp ? P_PC : (gm ? mpc : 32'd0),
              e_mrdy, !RESET && pr && gm);
`ifdef WB_ARB_STATS_EN
      chk($sformatf("rnd%0d.FORCE_CNT", i), FORCE_CNT, 32'(m_forces));
      chk($sformatf("rnd%0d.CONFLICT_CNT", i), CONFLICT_CNT, 32'(m_conflicts));
`endif
      if (RESET) begin
        denies = 0; m_forces = 0; m_conflicts = 0;
      end else begin
        if (pr && mrq) m_conflicts++;
        if (gm && frc) m_forces++;
        denies = gm ? 0 : ((pr && mrq) ? denies + 1 : denies);
        if (e_mrdy) mv = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
